// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite image loader (optional RLE input via SPRITE_RLE_EN).
package sprite_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} sprite_state_e;
  typedef enum logic [1:0] {RLE_COUNT, RLE_INDEX, RLE_RUN} sprite_rle_state_e;

  localparam logic SPRITE_BANK_POP = 1'b0;
  localparam logic SPRITE_BANK_ALT = 1'b1;

  // Address width covering both image banks.
  function automatic int unsigned sprite_addr_width(input int unsigned w, input int unsigned h);
    return $clog2(2 * w * h);
  endfunction

endpackage

// File: rtl/sprite_rle_expander.sv
// Expands (count, index) byte pairs into a one-pixel-per-cycle stream for the writer core.
module sprite_rle_expander
  import sprite_pkg::*;
(
  input  logic       pixel_clk_in,
  input  logic       rst_n_in,
  input  logic       load_c,
  input  logic [7:0] data_in,
  input  logic       data_valid_in,
  output logic       data_ready_out,
  output logic       pix_valid_c,
  output logic [7:0] pix_data_c
);

  sprite_rle_state_e rle_state, rle_state_n;
  logic [7:0] count_q, count_n;
  logic [7:0] index_q, index_n;
  logic [7:0] run_rem, run_rem_n;
  logic       ready_n;
  logic       accept;

  assign accept = data_valid_in && data_ready_out;

  // First pixel of a run passes straight through on the index handshake.
  assign pix_valid_c = (rle_state == RLE_RUN) || ((rle_state == RLE_INDEX) && accept);
  assign pix_data_c  = (rle_state == RLE_RUN) ? index_q : data_in;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rle_state      <= RLE_COUNT;
      count_q        <= 8'd0;
      index_q        <= 8'd0;
      run_rem        <= 8'd0;
      data_ready_out <= 1'b0;
    end else begin
      rle_state      <= rle_state_n;
      count_q        <= count_n;
      index_q        <= index_n;
      run_rem        <= run_rem_n;
      data_ready_out <= ready_n;
    end
  end

  always_comb begin
    rle_state_n = rle_state;
    count_n     = count_q;
    index_n     = index_q;
    run_rem_n   = run_rem;
    ready_n     = 1'b0;
    case (rle_state)
      RLE_COUNT: if (accept) begin
        count_n     = data_in;
        rle_state_n = RLE_INDEX;
      end
      RLE_INDEX: if (accept) begin
        index_n = data_in;
        if (count_q == 8'd1) begin
          rle_state_n = RLE_COUNT;
        end else begin
          // A count of 0 encodes 256, leaving 255 pixels after the pass-through one.
          run_rem_n   = count_q - 8'd1;
          rle_state_n = RLE_RUN;
        end
      end
      RLE_RUN: begin
        run_rem_n = run_rem - 8'd1;
        if (run_rem == 8'd1) rle_state_n = RLE_COUNT;
      end
      default: rle_state_n = RLE_COUNT;
    endcase
    if (!load_c) rle_state_n = RLE_COUNT;
    ready_n = load_c && (rle_state_n != RLE_RUN);
  end

endmodule

// File: rtl/sprite_image_writer.sv
// Writes a palette-index byte stream into one of two sprite BRAM banks; SPRITE_RLE_EN adds RLE input.
module sprite_image_writer
  import sprite_pkg::*;
#(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256
) (
  input  logic                                          pixel_clk_in,
  input  logic                                          rst_n_in,
  input  logic                                          start_in,
  input  logic                                          bank_in,
  input  logic                                          abort_in,
  input  logic [7:0]                                    data_in,
  input  logic                                          data_valid_in,
  output logic                                          data_ready_out,
  output logic [sprite_addr_width(WIDTH, HEIGHT)-1:0]   bram_addr_out,
  output logic [7:0]                                    bram_data_out,
  output logic                                          bram_we_out,
  output logic                                          busy_out,
  output logic                                          done_out
);

  localparam int unsigned PIX = WIDTH * HEIGHT;
  localparam int unsigned AW  = sprite_addr_width(WIDTH, HEIGHT);
  localparam int unsigned CW  = $clog2(PIX);

  sprite_state_e state, state_n;
  logic [AW-1:0] base_q, base_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic [AW-1:0] addr_n;
  logic [7:0]    data_n;
  logic          we_n, done_n;
  logic          load_c;
  logic          pix_valid_c;
  logic [7:0]    pix_data_c;

`ifdef SPRITE_RLE_EN
  sprite_rle_expander u_rle (
    .pixel_clk_in   (pixel_clk_in),
    .rst_n_in       (rst_n_in),
    .load_c         (load_c),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .data_ready_out (data_ready_out),
    .pix_valid_c    (pix_valid_c),
    .pix_data_c     (pix_data_c)
  );
`else
  logic ready_q;

  assign pix_valid_c    = data_valid_in && ready_q;
  assign pix_data_c     = data_in;
  assign data_ready_out = ready_q;

  // Ready follows the next state so it drops on the edge that takes the last pixel.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) ready_q <= 1'b0;
    else           ready_q <= load_c;
  end
`endif

  assign load_c = (state_n == ST_LOAD);

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= ST_IDLE;
      base_q        <= {AW{1'b0}};
      cnt_q         <= {CW{1'b0}};
      bram_addr_out <= {AW{1'b0}};
      bram_data_out <= 8'd0;
      bram_we_out   <= 1'b0;
      busy_out      <= 1'b0;
      done_out      <= 1'b0;
    end else begin
      state         <= state_n;
      base_q        <= base_n;
      cnt_q         <= cnt_n;
      bram_addr_out <= addr_n;
      bram_data_out <= data_n;
      bram_we_out   <= we_n;
      busy_out      <= (state_n != ST_IDLE);
      done_out      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    base_n  = base_q;
    cnt_n   = cnt_q;
    addr_n  = bram_addr_out;
    data_n  = bram_data_out;
    we_n    = 1'b0;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: if (start_in) begin
        base_n  = (bank_in == SPRITE_BANK_POP) ? {AW{1'b0}} : AW'(PIX);
        cnt_n   = {CW{1'b0}};
        state_n = ST_LOAD;
      end
      ST_LOAD: if (pix_valid_c) begin
        we_n   = 1'b1;
        addr_n = base_q + AW'(cnt_q);
        data_n = pix_data_c;
        cnt_n  = cnt_q + CW'(1);
        if (cnt_q == CW'(PIX - 1)) state_n = ST_DONE;
      end
      // DONE holds for the write cycle and the done pulse, keeping starts blocked until IDLE.
      ST_DONE: begin
        if (done_out) state_n = ST_IDLE;
        else          done_n  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (abort_in) begin
      state_n = ST_IDLE;
      we_n    = 1'b0;
      done_n  = 1'b0;
    end
  end

endmodule
